// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control and guard-band symbols, mode encodings,
// and the popcount helper used by the encoder.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTL0    = 10'b1101010100;
  localparam logic [9:0] TMDS_CTL1    = 10'b0010101011;
  localparam logic [9:0] TMDS_CTL2    = 10'b0101010100;
  localparam logic [9:0] TMDS_CTL3    = 10'b1010101011;
  localparam logic [9:0] TMDS_GB_CH02 = 10'b1011001100;
  localparam logic [9:0] TMDS_GB_CH1  = 10'b0100110011;

  // Mode 2'b11 is also treated as control.
  localparam logic [1:0] MODE_CTRL  = 2'b00;
  localparam logic [1:0] MODE_VIDEO = 2'b01;
  localparam logic [1:0] MODE_GUARD = 2'b10;

  function automatic logic [3:0] popcount8(input logic [7:0] x);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, x[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bus of one TMDS channel encoder: enable, mode, byte and control
// bits in; encoded symbol and running disparity out.
interface tmds_channel_encoder_if #(parameter int CNT_W = 5);
  logic             ce;
  logic [1:0]       mode;
  logic [7:0]       data;
  logic [1:0]       ctrl;
  logic [9:0]       symbol;
  logic [CNT_W-1:0] disparity;

  modport master (output ce, mode, data, ctrl, input symbol, disparity);
  modport slave  (input ce, mode, data, ctrl, output symbol, disparity);
endinterface

// File: rtl/tmds_channel_encoder.sv
// One-lane TMDS 8b/10b encoder: stage 1 builds the transition-minimised q_m,
// stage 2 applies DC balancing or emits control/guard-band symbols.
module tmds_channel_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  tmds_channel_encoder_if.slave bus
);

  logic [8:0]       qm_d;
  logic [8:0]       qm_q;
  logic [1:0]       mode_q;
  logic [1:0]       ctrl_q;
  logic [9:0]       sym_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    logic [3:0] n;
    logic       use_xnor;
    logic [8:0] q;
    n        = popcount8(bus.data);
    use_xnor = (n > 4'd4) || (n == 4'd4 && !bus.data[0]);
    q        = '0;
    q[0]     = bus.data[0];
    for (int i = 1; i < 8; i++)
      q[i] = use_xnor ? ~(q[i-1] ^ bus.data[i]) : (q[i-1] ^ bus.data[i]);
    q[8]     = ~use_xnor;
    qm_d     = q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      qm_q   <= '0;
      mode_q <= MODE_CTRL;
      ctrl_q <= 2'b00;
    end else if (bus.ce) begin
      qm_q   <= qm_d;
      mode_q <= bus.mode;
      ctrl_q <= bus.ctrl;
    end
  end

  // Returns {symbol, next disparity}. diff = n1-n0 = 2*n1-8, held in CNT_W bits.
  function automatic logic [10+CNT_W-1:0] encode_video(input logic [8:0] qm,
                                                       input logic [CNT_W-1:0] cnt);
    logic [3:0]       n1;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] two_q8;
    logic [CNT_W-1:0] two_nq8;
    logic             cnt_zero;
    logic             cnt_neg;
    logic             cnt_pos;
    logic [9:0]       sym;
    logic [CNT_W-1:0] nxt;
    n1       = popcount8(qm[7:0]);
    diff     = CNT_W'({n1, 1'b0}) - CNT_W'(8);
    two_q8   = CNT_W'({qm[8], 1'b0});
    two_nq8  = CNT_W'({~qm[8], 1'b0});
    cnt_zero = (cnt == '0);
    cnt_neg  = cnt[CNT_W-1];
    cnt_pos  = !cnt_zero && !cnt_neg;
    if (cnt_zero || n1 == 4'd4) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      nxt = qm[8] ? cnt + diff : cnt - diff;
    end else if ((cnt_pos && n1 > 4'd4) || (cnt_neg && n1 < 4'd4)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      nxt = cnt + two_q8 - diff;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      nxt = cnt + diff - two_nq8;
    end
    return {sym, nxt};
  endfunction

  // Stage 2: guard band leaves the disparity untouched, control clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sym_q <= TMDS_CTL0;
      cnt_q <= '0;
    end else if (bus.ce) begin
      case (mode_q)
        MODE_VIDEO: {sym_q, cnt_q} <= encode_video(qm_q, cnt_q);
        MODE_GUARD: sym_q <= (CHANNEL == 1) ? TMDS_GB_CH1 : TMDS_GB_CH02;
        default: begin
          cnt_q <= '0;
          case (ctrl_q)
            2'b00:   sym_q <= TMDS_CTL0;
            2'b01:   sym_q <= TMDS_CTL1;
            2'b10:   sym_q <= TMDS_CTL2;
            default: sym_q <= TMDS_CTL3;
          endcase
        end
      endcase
    end
  end

  assign bus.symbol    = sym_q;
  assign bus.disparity = cnt_q;

endmodule
